// File: rtl/operand_matcher.sv
// ============================================================================
// Module  : operand_matcher
// Purpose : Pairs dyadic worker results by {dest_addr, color}; monadic bypass.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module operand_matcher #(
    parameter int DEPTH     = 8,
    parameter int IDX_WIDTH = 3
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 RECEIVE_WR_VALID,
    output logic                 RECEIVE_WR_READY,
    input  logic [66:0]          RECEIVE_WR_DATA,
    output logic                 SEND_MT_VALID,
    input  logic                 SEND_MT_READY,
    output logic [95:0]          SEND_MT_DATA,
    output logic [IDX_WIDTH:0]   OCCUPANCY,
    output logic                 OVERFLOW
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        SEND   = 2'd2
    } state_t;

    state_t state, state_next;

    logic [65:0]      in_tok;
    logic [95:0]      mt_data;
    logic [IDX_WIDTH:0] occupancy;
    logic             overflow;

    logic [DEPTH-1:0] ent_valid;
    logic [DEPTH-1:0] ent_port;
    logic [15:0]      ent_addr  [DEPTH];
    logic [15:0]      ent_color [DEPTH];
    logic [31:0]      ent_data  [DEPTH];

    // dest_option bit 2 is reserved and intentionally discarded
    logic unused_reserved;
    assign unused_reserved = RECEIVE_WR_DATA[66];

    logic        in_dyadic, in_port;
    logic [15:0] in_addr, in_color;
    logic [31:0] in_data;
    assign in_dyadic = in_tok[65];
    assign in_port   = in_tok[64];
    assign in_addr   = in_tok[63:48];
    assign in_color  = in_tok[47:32];
    assign in_data   = in_tok[31:0];

    logic [DEPTH-1:0] hit_sel, free_sel;
    logic             hit, free_found;
    logic [31:0]      partner_data;

    // Descending scan so the lowest matching/free index wins
    always_comb begin
        hit_sel      = '0;
        free_sel     = '0;
        hit          = 1'b0;
        free_found   = 1'b0;
        partner_data = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ent_valid[i] && ent_addr[i] == in_addr && ent_color[i] == in_color &&
                ent_port[i] != in_port) begin
                hit          = 1'b1;
                hit_sel      = '0;
                hit_sel[i]   = 1'b1;
                partner_data = ent_data[i];
            end
            if (!ent_valid[i]) begin
                free_found  = 1'b1;
                free_sel    = '0;
                free_sel[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (RECEIVE_WR_VALID) state_next = LOOKUP;
            LOOKUP:  state_next = (!in_dyadic || hit) ? SEND : IDLE;
            SEND:    if (SEND_MT_READY) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            in_tok    <= '0;
            mt_data   <= '0;
            occupancy <= '0;
            overflow  <= 1'b0;
            ent_valid <= '0;
            ent_port  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr[i]  <= '0;
                ent_color[i] <= '0;
                ent_data[i]  <= '0;
            end
        end else begin
            if (state == IDLE && RECEIVE_WR_VALID) in_tok <= RECEIVE_WR_DATA[65:0];
            if (state == LOOKUP) begin
                if (!in_dyadic) begin
                    mt_data <= {in_addr, in_color, in_data, 32'h0};
                end else if (hit) begin
                    // Left operand always comes from the port-0 token
                    mt_data   <= in_port ? {in_addr, in_color, partner_data, in_data}
                                         : {in_addr, in_color, in_data, partner_data};
                    ent_valid <= ent_valid & ~hit_sel;
                    occupancy <= occupancy - (IDX_WIDTH+1)'(1);
                end else if (free_found) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (free_sel[i]) begin
                            ent_valid[i] <= 1'b1;
                            ent_port[i]  <= in_port;
                            ent_addr[i]  <= in_addr;
                            ent_color[i] <= in_color;
                            ent_data[i]  <= in_data;
                        end
                    end
                    occupancy <= occupancy + (IDX_WIDTH+1)'(1);
                end else begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    // READY gated by RST so it is low throughout the reset interval
    assign RECEIVE_WR_READY = (state == IDLE) && !RST;
    assign SEND_MT_VALID    = (state == SEND);
    assign SEND_MT_DATA     = mt_data;
    assign OCCUPANCY        = occupancy;
    assign OVERFLOW         = overflow;

endmodule

`default_nettype wire

// File: tb/tb_operand_matcher.sv
// ============================================================================
// Module  : tb_operand_matcher
// Purpose : Directed-vector scoreboard bench for operand_matcher.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_operand_matcher;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [66:0] wr_data = '0;
    logic        mt_valid;
    logic        mt_ready = 1'b1;
    logic [95:0] mt_data;
    logic [3:0]  occupancy;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    logic [95:0] exp_q[$];

    operand_matcher #(.DEPTH(8), .IDX_WIDTH(3)) dut (
        .CLK              (CLK),
        .RST              (RST),
        .RECEIVE_WR_VALID (wr_valid),
        .RECEIVE_WR_READY (wr_ready),
        .RECEIVE_WR_DATA  (wr_data),
        .SEND_MT_VALID    (mt_valid),
        .SEND_MT_READY    (mt_ready),
        .SEND_MT_DATA     (mt_data),
        .OCCUPANCY        (occupancy),
        .OVERFLOW         (overflow)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: a transfer happens on the edge after VALID&&READY is seen
    always @(negedge CLK) begin
        if (mt_valid && mt_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mt_unexpected: got %0h expected none", mt_data);
            end else begin
                check("mt_data", mt_data, exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [66:0] d);
        bit ok = 1'b0;
        @(posedge CLK); #1;
        wr_valid = 1'b1;
        wr_data  = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (wr_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send_timeout: got ready=0 expected ready=1");
        end
        @(posedge CLK); #1;
        wr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (wr_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL idle_timeout: got ready=0 expected ready=1");
        end
    endtask

    task automatic wait_valid();
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (mt_valid) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL valid_timeout: got valid=0 expected valid=1");
        end
    endtask

    task automatic pair_match(input logic [15:0] a, input logic [15:0] c,
                              input logic [31:0] dl, input logic [31:0] dr);
        send({3'b011, a, c, dr});
        wait_idle();
        check("pair_occ_store", 96'(occupancy), 96'd1);
        exp_q.push_back({a, c, dl, dr});
        send({3'b010, a, c, dl});
        wait_idle();
        check("pair_occ_clear", 96'(occupancy), 96'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        // Reset values
        #2;
        check("rst_wr_ready", 96'(wr_ready), 96'd0);
        check("rst_mt_valid", 96'(mt_valid), 96'd0);
        check("rst_mt_data", mt_data, 96'd0);
        check("rst_occ", 96'(occupancy), 96'd0);
        check("rst_ovf", 96'(overflow), 96'd0);
        @(negedge CLK); RST = 1'b0;

        // Monadic bypass with latency check
        exp_q.push_back({16'h0f0f, 16'habcd, 32'h1234_abcd, 32'h0});
        send({3'b000, 16'h0f0f, 16'habcd, 32'h1234_abcd});
        @(negedge CLK);
        check("mon_lookup_valid", 96'(mt_valid), 96'd0);
        @(negedge CLK);
        check("mon_send_valid", 96'(mt_valid), 96'd1);
        wait_idle();
        check("mon_occ", 96'(occupancy), 96'd0);

        // Pair match, right first
        pair_match(16'h00ff, 16'heeee, 32'hdead_0000, 32'h0000_beef);

        // Color isolation
        send({3'b010, 16'hdead, 16'h0f0f, 32'h1111_0000});
        send({3'b010, 16'hdead, 16'hbadc, 32'h2222_0000});
        wait_idle();
        check("color_occ2", 96'(occupancy), 96'd2);
        exp_q.push_back({16'hdead, 16'hbadc, 32'h2222_0000, 32'h0000_3333});
        send({3'b011, 16'hdead, 16'hbadc, 32'h0000_3333});
        wait_idle();
        check("color_occ1", 96'(occupancy), 96'd1);
        exp_q.push_back({16'hdead, 16'h0f0f, 32'h1111_0000, 32'h0000_4444});
        send({3'b011, 16'hdead, 16'h0f0f, 32'h0000_4444});
        wait_idle();
        check("color_occ0", 96'(occupancy), 96'd0);

        // Backpressure during a match
        mt_ready = 1'b0;
        send({3'b011, 16'h0042, 16'h0007, 32'h0000_00bb});
        exp_q.push_back({16'h0042, 16'h0007, 32'h0000_00aa, 32'h0000_00bb});
        send({3'b010, 16'h0042, 16'h0007, 32'h0000_00aa});
        wait_valid();
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            check("bp_valid", 96'(mt_valid), 96'd1);
            check("bp_data", mt_data, {16'h0042, 16'h0007, 32'h0000_00aa, 32'h0000_00bb});
            check("bp_wr_ready", 96'(wr_ready), 96'd0);
        end
        @(posedge CLK); #1;
        mt_ready = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        check("bp_single", 96'(mt_valid), 96'd0);
        check("bp_occ", 96'(occupancy), 96'd0);

        // Overflow
        for (int i = 0; i < 8; i++) begin
            send({3'b010, 16'(i), 16'h0000, 32'(i)});
            wait_idle();
        end
        check("ovf_occ_full", 96'(occupancy), 96'd8);
        check("ovf_clear_before", 96'(overflow), 96'd0);
        send({3'b010, 16'h0100, 16'h0000, 32'h0000_0077});
        wait_idle();
        check("ovf_set", 96'(overflow), 96'd1);
        check("ovf_occ_same", 96'(occupancy), 96'd8);
        exp_q.push_back({16'h0003, 16'h0000, 32'h0000_0003, 32'h0000_0099});
        send({3'b011, 16'h0003, 16'h0000, 32'h0000_0099});
        wait_idle();
        check("ovf_occ_after_match", 96'(occupancy), 96'd7);
        check("ovf_sticky", 96'(overflow), 96'd1);

        // Async reset while SEND is pending
        mt_ready = 1'b0;
        send({3'b000, 16'h5555, 16'h6666, 32'h7777_8888});
        wait_valid();
        #2;
        RST = 1'b1;
        #1;
        check("arst_valid", 96'(mt_valid), 96'd0);
        check("arst_ready", 96'(wr_ready), 96'd0);
        check("arst_occ", 96'(occupancy), 96'd0);
        check("arst_ovf", 96'(overflow), 96'd0);
        @(negedge CLK);
        RST = 1'b0;
        mt_ready = 1'b1;

        for (int r = 0; r < 10; r++) begin
            pair_match(16'h0100 + 16'(r), 16'(r * 3), 32'h2000_0000 + 32'(r), 32'h0000_1000 + 32'(r));
        end

        repeat (3) @(negedge CLK);
        check("sb_drained", 96'(exp_q.size()), 96'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
